// File: rtl/down_counter_8b.sv
// Loadable down-counter/timer with one-shot or periodic reload and a
// registered one-cycle terminal-count pulse.
module down_counter_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_i,
  input  logic             dec_i,
  input  logic             auto_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             zero_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // State register; reset overrides everything, including a pending tc.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next state: load beats decrement; terminal step reloads or stops.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (ld_i) begin
      count_d  = in_i;
      reload_d = in_i;
      // Loading zero doubles as abort.
      state_d  = (in_i != '0) ? RUN : IDLE;
    end else if (state_q == RUN && dec_i) begin
      if (count_q == ONE) begin
        tc_d = 1'b1;
        if (auto_i) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end else if (count_q > ONE) begin
        count_d = count_q - ONE;
      end
    end
  end

  assign out_o  = count_q;
  assign busy_o = (state_q == RUN);
  assign tc_o   = tc_q;
  assign zero_o = (count_q == '0);

endmodule

// File: tb/tb_down_counter_8b.sv
// Directed, table-driven bench for down_counter_8b.
module tb_down_counter_8b;

  logic       clk = 1'b0;
  logic       rst, ld, dec, auto_m;
  logic [7:0] in_v;
  logic [7:0] out_v;
  logic       busy, tc, zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       dec;
    logic       auto_m;
    logic [7:0] in_v;
    logic [7:0] e_out;
    logic       e_busy;
    logic       e_tc;
    logic       e_zero;
  } vec_t;

  vec_t vecs[$];

  down_counter_8b #(.WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ld_i  (ld),
    .dec_i (dec),
    .auto_i(auto_m),
    .in_i  (in_v),
    .out_o (out_v),
    .busy_o(busy),
    .tc_o  (tc),
    .zero_o(zero)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic l, input logic d, input logic a,
                     input logic [7:0] i, input logic [7:0] eo, input logic eb,
                     input logic et, input logic ez);
    vec_t v;
    v.rst = r; v.ld = l; v.dec = d; v.auto_m = a; v.in_v = i;
    v.e_out = eo; v.e_busy = eb; v.e_tc = et; v.e_zero = ez;
    vecs.push_back(v);
  endtask

  // Drive inputs away from the edge, then sample 1ns after the edge.
  task automatic step(input logic r, input logic l, input logic d, input logic a,
                      input logic [7:0] i);
    @(negedge clk);
    rst = r; ld = l; dec = d; auto_m = a; in_v = i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] eo, input logic eb,
                     input logic et, input logic ez);
    checks++;
    if (out_v !== eo || busy !== eb || tc !== et || zero !== ez) begin
      errors++;
      $display("FAIL %s: got out=%0d busy=%b tc=%b zero=%b, want out=%0d busy=%b tc=%b zero=%b",
               name, out_v, busy, tc, zero, eo, eb, et, ez);
    end
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; dec = 1'b0; auto_m = 1'b0; in_v = 8'h00;

    //   rst ld dec auto in      out busy tc zero
    // reset held two cycles with a competing load
    add(1, 1, 0, 0, 8'h55,  8'd0, 0, 0, 1);
    add(1, 1, 0, 0, 8'h55,  8'd0, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00,  8'd0, 0, 0, 1);   // dec ignored in IDLE
    // one-shot from 3
    add(0, 1, 0, 0, 8'd3,   8'd3, 1, 0, 0);
    add(0, 0, 1, 0, 8'd0,   8'd2, 1, 0, 0);
    add(0, 0, 1, 0, 8'd0,   8'd1, 1, 0, 0);
    add(0, 0, 1, 0, 8'd0,   8'd0, 0, 1, 1);
    add(0, 0, 1, 0, 8'd0,   8'd0, 0, 0, 1);
    add(0, 0, 1, 0, 8'd0,   8'd0, 0, 0, 1);
    // periodic from 4 with a two-cycle pause at 2
    add(0, 1, 0, 1, 8'd4,   8'd4, 1, 0, 0);
    add(0, 0, 1, 1, 8'd0,   8'd3, 1, 0, 0);
    add(0, 0, 1, 1, 8'd0,   8'd2, 1, 0, 0);
    add(0, 0, 0, 1, 8'd0,   8'd2, 1, 0, 0);
    add(0, 0, 0, 1, 8'd0,   8'd2, 1, 0, 0);
    add(0, 0, 1, 1, 8'd0,   8'd1, 1, 0, 0);
    add(0, 0, 1, 1, 8'd0,   8'd4, 1, 1, 0);
    add(0, 0, 1, 1, 8'd0,   8'd3, 1, 0, 0);
    add(0, 0, 1, 1, 8'd0,   8'd2, 1, 0, 0);
    add(0, 0, 1, 1, 8'd0,   8'd1, 1, 0, 0);
    // load coincident with terminal step wins
    add(0, 1, 1, 1, 8'h0A,  8'd10, 1, 0, 0);
    add(0, 0, 1, 1, 8'd0,   8'd9, 1, 0, 0);
    // abort by loading zero, then no underflow
    add(0, 1, 0, 0, 8'd7,   8'd7, 1, 0, 0);
    add(0, 1, 1, 0, 8'd0,   8'd0, 0, 0, 1);
    add(0, 0, 1, 0, 8'd0,   8'd0, 0, 0, 1);
    add(0, 0, 1, 1, 8'd0,   8'd0, 0, 0, 1);
    // periodic N = 1: tc every cycle
    add(0, 1, 0, 1, 8'd1,   8'd1, 1, 0, 0);
    add(0, 0, 1, 1, 8'd0,   8'd1, 1, 1, 0);
    add(0, 0, 1, 1, 8'd0,   8'd1, 1, 1, 0);
    // auto dropped just before the terminal step: one-shot ending
    add(0, 0, 1, 0, 8'd0,   8'd0, 0, 1, 1);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].ld, vecs[k].dec, vecs[k].auto_m, vecs[k].in_v);
      chk($sformatf("vec%0d", k), vecs[k].e_out, vecs[k].e_busy, vecs[k].e_tc, vecs[k].e_zero);
    end

    // Full range: load 255, 100 decrements -> 155
    step(0, 1, 0, 0, 8'hFF);
    chk("load_ff", 8'd255, 1, 0, 0);
    for (int n = 1; n <= 100; n++) begin
      step(0, 0, 1, 0, 8'h00);
      if (n == 50) chk("ff_mid", 8'd205, 1, 0, 0);
    end
    chk("ff_100", 8'd155, 1, 0, 0);
    // reset mid-count, dec still high
    step(1, 0, 1, 0, 8'h00);
    chk("rst_mid", 8'd0, 0, 0, 1);
    step(0, 0, 1, 0, 8'h00);
    chk("post_rst", 8'd0, 0, 0, 1);

    // reset on the terminal-step edge suppresses tc
    step(0, 1, 0, 0, 8'd1);
    chk("load_1", 8'd1, 1, 0, 0);
    step(1, 0, 1, 1, 8'h00);
    chk("rst_tc", 8'd0, 0, 0, 1);

    // reload register replaced by a load while running
    step(0, 1, 0, 1, 8'd5);
    step(0, 0, 1, 1, 8'h00);
    step(0, 1, 0, 1, 8'd2);
    chk("reld_2", 8'd2, 1, 0, 0);
    step(0, 0, 1, 1, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    chk("reld_wrap", 8'd2, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_counter_8b.md
# down_counter_8b

Loadable down-counter/timer, the decrementing counterpart of the team's 8-bit load/increment register. It takes a parallel start value, counts down on an enable, and flags terminal count with a one-cycle pulse. It can either stop at zero (one-shot) or reload the start value automatically (periodic). It sits beside the up-counting register in the simulation designs as the timing/event source driven by the same testbench style.

## Interface

Parameters:
- WIDTH, 8, counter and data width in bits

Ports:
- clk, input, 1, system clock; all state changes on the rising edge
- rst, input, 1, synchronous, active-high reset; sampled on the rising edge of clk
- ld, input, 1, load strobe; captures in as count and reload value
- dec, input, 1, decrement enable; counts one step per cycle while RUN
- auto, input, 1, reload mode; 1 = periodic, 0 = one-shot; sampled at the terminal step
- in, input, WIDTH, start/reload value
- out, output, WIDTH, current count (registered)
- busy, output, 1, high while in RUN (registered)
- tc, output, 1, terminal-count pulse, one cycle wide (registered)
- zero, output, 1, combinational, (out == 0)

## Operation

- Internal state: count register (drives out), reload register (WIDTH), FSM state {IDLE, RUN}, tc flag.
- Reset (rst = 1 at the edge): out = 0, reload = 0, state = IDLE, busy = 0, tc = 0; zero = 1. Reset overrides ld and dec.
- Priority each cycle: rst > ld > dec.
- ld = 1 (any state): out <= in, reload <= in, tc <= 0.
  - in != 0: state <= RUN.
  - in == 0: state <= IDLE. Loading 0 is the abort mechanism.
- IDLE: out holds; dec is ignored; tc <= 0.
- RUN, dec = 0: out holds (pause); tc <= 0.
- RUN, dec = 1, out > 1: out <= out − 1; tc <= 0.
- RUN, dec = 1, out == 1 (terminal step): tc <= 1.
  - auto = 1: out <= reload; state stays RUN.
  - auto = 0: out <= 0; state <= IDLE.
- Period in auto mode with dec held high is N cycles for load value N; the count sequence is N, N−1, …, 1, N, ….
- No wrap-around: the counter never decrements below 0. dec is a no-op when out == 0, because state is IDLE then.
- busy mirrors state: busy = 1 exactly when state = RUN.
- Arithmetic is unsigned, WIDTH bits. A load of 2^WIDTH−1 (255 at WIDTH = 8) is legal and counts the full range.

## Timing

- All outputs except zero are registered; they change only on the rising clk edge.
- Load latency: in appears on out, and busy reflects the new state, one cycle after the edge where ld = 1.
- Decrement latency: one cycle per step.
- tc goes high in the same cycle that out first shows the post-terminal value (0 or reload), for exactly one cycle.
  - In auto mode with dec held high, N = 1 gives tc high every cycle.
- ld coincident with a terminal step: ld wins. out <= in, tc stays 0, and auto is not consulted.
- ld while RUN restarts the count immediately with the new value and replaces reload.
- rst during RUN: at the next edge all state returns to reset values. A tc pending from that same edge is suppressed.
- auto may change at any time; only its value at the terminal-step edge matters.

## Test plan

- Reset: assert rst 2 cycles with ld = 1, in = 8'h55 → out = 0, busy = 0, tc = 0, zero = 1.
- One-shot: load 3, auto = 0, dec held 1 → out 3, 2, 1, 0. tc = 1 only in the cycle out = 0; busy falls in that same cycle; further dec leaves out = 0.
- Periodic with pause: load 4, auto = 1, dec = 1 except dec = 0 for 2 cycles at out = 2.
  - out 4, 3, 2, 2, 2, 1, 4, 3, ….
  - tc high in each cycle out returns to 4; busy stays 1.
- Priority at terminal step: out = 1, RUN, dec = 1 and ld = 1 with in = 8'h0A on the same edge → out = 10, tc = 0, busy = 1.
- Abort and no-underflow: in RUN at out = 7, ld with in = 0 → out = 0, busy = 0, tc = 0; subsequent dec pulses keep out = 0.
- Full range and reset mid-count: load 8'hFF, auto = 0, run 100 cycles → out = 155; assert rst → out = 0 and busy = 0 next cycle, no tc pulse.
